// File: rtl/genram_writer.sv
// Burst byte writer: takes one right-aligned request of extra+1 bytes and writes
// them MSB-first, one byte per cycle, to a single-port byte RAM after a bounds check.
module genram_writer #(
    parameter int AW    = 4,
    parameter int DW    = 8,
    parameter int EXTRA = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [AW:0]                 addr,
    input  logic [EXTRA-1:0]            extra,
    input  logic [AW:0]                 lower_bound,
    input  logic [AW:0]                 upper_bound,
    input  logic [DW*(2**EXTRA)-1:0]    data,
    output logic                        mem_we,
    output logic [AW:0]                 mem_addr,
    output logic [DW-1:0]               mem_wdata,
    output logic                        busy,
    output logic                        done,
    output logic                        error
);

    localparam int PW = DW * (2**EXTRA);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t             state, state_d;
    logic [EXTRA-1:0]   extra_q, extra_d;
    logic [EXTRA-1:0]   idx_q, idx_d;
    logic [EXTRA-1:0]   sel;
    logic [PW-1:0]      data_q, data_d;
    logic               mem_we_d, busy_d, done_d, error_d;
    logic [AW:0]        mem_addr_d;
    logic [DW-1:0]      mem_wdata_d;
    logic [AW+1:0]      end_addr;
    logic               reject;

    assign req_ready = (state == IDLE);

    // One extra bit keeps addr+extra from wrapping past the top of the RAM.
    assign end_addr = {1'b0, addr} + (AW+2)'(extra);
    assign reject   = (addr < lower_bound) || (end_addr > {1'b0, upper_bound});

    // Byte index (from the LSB end) of the write following idx_q.
    assign sel = extra_q - idx_q - 1'b1;

    always_comb begin
        state_d     = state;
        extra_d     = extra_q;
        idx_d       = idx_q;
        data_d      = data_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        error_d     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (reject) begin
                        error_d = 1'b1;
                    end else begin
                        state_d     = WRITE;
                        extra_d     = extra;
                        data_d      = data;
                        idx_d       = '0;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = addr;
                        mem_wdata_d = DW'(data >> (int'(extra) * DW));
                        busy_d      = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (idx_q == extra_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d       = idx_q + 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = mem_addr + 1'b1;
                    mem_wdata_d = DW'(data_q >> (int'(sel) * DW));
                    busy_d      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            extra_q   <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_d;
            extra_q   <= extra_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            busy      <= busy_d;
            done      <= done_d;
            error     <= error_d;
        end
    end

endmodule

// File: tb/tb_genram_writer.sv
// Self-checking bench for genram_writer: directed vector table, hand-written
// back-to-back / reset / round-trip sequences, then randomized requests vs a RAM model.
module tb_genram_writer;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int EXTRA = 4;
    localparam int PW    = DW * (2**EXTRA);
    localparam int DEPTH = 2**(AW+1);

    logic               clk = 1'b0;
    logic               rst_n;
    logic               req_valid;
    logic               req_ready;
    logic [AW:0]        addr;
    logic [EXTRA-1:0]   extra;
    logic [AW:0]        lower_bound;
    logic [AW:0]        upper_bound;
    logic [PW-1:0]      data;
    logic               mem_we;
    logic [AW:0]        mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic               busy;
    logic               done;
    logic               error;

    genram_writer #(.AW(AW), .DW(DW), .EXTRA(EXTRA)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .addr(addr), .extra(extra), .lower_bound(lower_bound), .upper_bound(upper_bound),
        .data(data), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // RAM driven by the DUT write port, plus the bench's expected contents.
    logic [DW-1:0] ram  [DEPTH];
    logic [DW-1:0] mram [DEPTH];
    logic          ram_clr;

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Byte i of the payload counted from the least significant end.
    function automatic logic [DW-1:0] get_byte(input logic [PW-1:0] d, input int i);
        return d[i*DW +: DW];
    endfunction

    function automatic bit model_reject(input int a, input int e, input int lo, input int hi);
        return (a < lo) || (a + e > hi);
    endfunction

    task automatic present(input int a, input int e, input int lo, input int hi, input logic [PW-1:0] d);
        addr        = AW'(0) | (AW+1)'(a);
        extra       = EXTRA'(e);
        lower_bound = (AW+1)'(lo);
        upper_bound = (AW+1)'(hi);
        data        = d;
        req_valid   = 1'b1;
        chk("ready_before_req", req_ready, 1);
    endtask

    // Called at the first negedge after the accepting edge; returns at the
    // negedge showing done (or error).
    task automatic check_resp(input int a, input int e, input logic [PW-1:0] d, input bit exp_err);
        if (exp_err) begin
            chk("err_pulse", error, 1);
            chk("err_no_we", mem_we, 0);
            chk("err_no_done", done, 0);
            chk("err_ready", req_ready, 1);
        end else begin
            for (int k = 0; k <= e; k++) begin
                chk("we", mem_we, 1);
                chk("waddr", mem_addr, a + k);
                chk("wdata", mem_wdata, get_byte(d, e - k));
                chk("busy", busy, 1);
                chk("ready_in_burst", req_ready, 0);
                chk("no_early_done", done, 0);
                chk("no_error", error, 0);
                mram[a + k] = get_byte(d, e - k);
                @(negedge clk);
            end
            chk("done", done, 1);
            chk("done_we_low", mem_we, 0);
            chk("done_busy_low", busy, 0);
            chk("done_no_error", error, 0);
            chk("done_ready", req_ready, 1);
        end
    endtask

    task automatic compare_ram(input string name);
        for (int i = 0; i < DEPTH; i++) chk(name, ram[i], mram[i]);
    endtask

    typedef struct {
        int            a;
        int            e;
        int            lo;
        int            hi;
        logic [PW-1:0] d;
        bit            exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [PW-1:0] d, d2;
        int a, e, lo, hi;
        bit rej;

        vecs[0] = '{0,  0,  0, 9,  128'h81,                 1'b0};
        vecs[1] = '{3,  3,  0, 9,  128'h00840088,           1'b0};
        vecs[2] = '{9,  0,  0, 9,  128'h5A,                 1'b0};
        vecs[3] = '{9,  1,  0, 9,  128'h1234,               1'b1};
        vecs[4] = '{10, 0,  0, 9,  128'h77,                 1'b1};
        vecs[5] = '{2,  0,  3, 9,  128'h66,                 1'b1};
        vecs[6] = '{3,  6,  3, 9,  128'hC1C2C3C4C5C6C7,     1'b0};
        vecs[7] = '{31, 15, 0, 31, 128'hFF,                 1'b1};

        for (int i = 0; i < DEPTH; i++) mram[i] = '0;
        rst_n = 1'b0; ram_clr = 1'b1; req_valid = 1'b0;
        addr = '0; extra = '0; lower_bound = '0; upper_bound = '0; data = '0;
        repeat (3) @(negedge clk);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        rst_n = 1'b1; ram_clr = 1'b0;
        @(negedge clk);
        chk("rst_ready", req_ready, 1);

        // Directed vectors; inputs are scrambled after accept to prove sampling.
        for (int i = 0; i < 8; i++) begin
            present(vecs[i].a, vecs[i].e, vecs[i].lo, vecs[i].hi, vecs[i].d);
            @(posedge clk); @(negedge clk);
            req_valid = 1'b0; data = ~vecs[i].d; addr = ~addr; extra = ~extra;
            check_resp(vecs[i].a, vecs[i].e, vecs[i].d, vecs[i].exp_err);
        end
        compare_ram("ram_after_table");

        // Back-to-back: second request held valid through the first burst.
        d  = 128'h8100820084008800;
        d2 = 128'h3132;
        present(0, 7, 0, 9, d);
        @(posedge clk); @(negedge clk);
        addr = 5'd8; extra = 4'd1; data = d2;
        check_resp(0, 7, d, 1'b0);
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        check_resp(8, 1, d2, 1'b0);

        // Reset asserted while the second write of a burst is on the port.
        d = 128'hA1A2A3A4A5A6A7A8;
        present(0, 7, 0, 9, d);
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        chk("rst_mid_w0", mem_we, 1);
        mram[0] = get_byte(d, 7);
        @(negedge clk);
        chk("rst_mid_w1_addr", mem_addr, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we", mem_we, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_ready", req_ready, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_mid_no_done", done, 0);
            chk("rst_mid_no_we", mem_we, 0);
        end
        chk("rst_mid_mem0", ram[0], 8'hA1);
        for (int i = 2; i < 8; i++) chk("rst_mid_untouched", ram[i], mram[i]);

        // Round trip of a full 16-byte burst, data changed while writing.
        d = {$urandom, $urandom, $urandom, $urandom};
        present(0, 15, 0, 31, d);
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0; data = ~d;
        check_resp(0, 15, d, 1'b0);
        for (int k = 0; k < 16; k++) chk("roundtrip", ram[k], get_byte(d, 15 - k));

        // Randomized requests against the model.
        for (int n = 0; n < 40; n++) begin
            lo  = $urandom_range(0, 15);
            hi  = $urandom_range(lo, 31);
            a   = $urandom_range(lo > 0 ? lo - 1 : 0, 31);
            e   = $urandom_range(0, 15);
            d   = {$urandom, $urandom, $urandom, $urandom};
            rej = model_reject(a, e, lo, hi);
            present(a, e, lo, hi, d);
            @(posedge clk); @(negedge clk);
            req_valid = 1'b0; data = {$urandom, $urandom, $urandom, $urandom};
            check_resp(a, e, d, rej);
        end
        @(negedge clk);
        compare_ram("ram_final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
